// File: rtl/mprj_io_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module : mprj_io_cfg_pkg
// Brief  : Shared state encoding and width helpers for the GPIO pad
//          configuration sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package mprj_io_cfg_pkg;

    localparam int unsigned c_state_w = 2;

    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_shift = 2'd1;
    localparam state_t c_st_load  = 2'd2;
    localparam state_t c_st_done  = 2'd3;

    // A single-pad chain still needs a one-bit address port.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned total_bits(input int unsigned pads,
                                               input int unsigned bits);
        return pads * bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mprj_io_serial_clkgen.sv
`default_nettype none
// ============================================================================
// Module : mprj_io_serial_clkgen
// Brief  : Divided serial shift clock: low for CLK_DIV cycles, then high for
//          CLK_DIV cycles, with one-cycle rise/fall ticks.
// Rev    : 1.0  initial release
// ============================================================================
module mprj_io_serial_clkgen
    import mprj_io_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
)(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_rise_tick,
    output logic o_fall_tick,
    output logic o_serial_clock
);

    localparam int unsigned               c_cnt_w = cnt_width(CLK_DIV);
    localparam logic [c_cnt_w-1:0]        c_last  = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               w_wrap;

    assign w_wrap = i_en && (r_cnt == c_last);

    // Disabling restarts the phase so every enable begins with a full low half.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_rise_tick    = w_wrap && !r_level;
    assign o_fall_tick    = w_wrap &&  r_level;
    assign o_serial_clock = r_level;

endmodule
`default_nettype wire

// File: rtl/mprj_io_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mprj_io_cfg_sequencer
// Brief  : Shadow config words per pad, shifted MSB-first down the pad
//          daisy chain (highest pad first), followed by a common load strobe.
// Rev    : 1.0  initial release
// ============================================================================
module mprj_io_cfg_sequencer
    import mprj_io_cfg_pkg::*;
#(
    parameter int unsigned          NUM_PADS    = 38,
    parameter int unsigned          CFG_BITS    = 13,
    parameter int unsigned          CLK_DIV     = 2,
    parameter logic [CFG_BITS-1:0]  DEFAULT_CFG = 13'h1803,
    parameter bit                   AUTO_LOAD   = 1'b1
)(
    input  logic                              clock,
    input  logic                              reset,
    input  logic [addr_width(NUM_PADS)-1:0]   cfg_addr,
    input  logic [CFG_BITS-1:0]               cfg_wdata,
    input  logic                              cfg_we,
    output logic [CFG_BITS-1:0]               cfg_rdata,
    output logic                              cfg_wr_err,
    input  logic                              xfer_start,
    output logic                              xfer_busy,
    output logic                              xfer_done,
    output logic                              serial_clock,
    output logic                              serial_data,
    output logic                              serial_load,
    output logic                              serial_resetn
);

    localparam int unsigned c_addr_w = addr_width(NUM_PADS);
    localparam int unsigned c_total  = total_bits(NUM_PADS, CFG_BITS);
    localparam int unsigned c_bcnt_w = cnt_width(c_total);
    localparam int unsigned c_flat_w = 1 << c_bcnt_w;
    localparam int unsigned c_dcnt_w = cnt_width(CLK_DIV);

    localparam logic [c_bcnt_w-1:0] c_last_bit  = c_bcnt_w'(c_total - 1);
    localparam logic [c_dcnt_w-1:0] c_load_last = c_dcnt_w'(CLK_DIV - 1);
    localparam logic [c_addr_w:0]   c_num_pads  = (c_addr_w + 1)'(NUM_PADS);

    logic [CFG_BITS-1:0] r_shadow [NUM_PADS];
    state_t              r_state;
    logic [c_bcnt_w-1:0] r_bit_cnt;
    logic [c_dcnt_w-1:0] r_load_cnt;
    logic                r_last_bit;
    logic                r_auto_pend;
    logic                r_wr_err;
    logic                r_serial_resetn;

    logic                w_addr_ok;
    logic                w_wr_ok;
    logic                w_shift_en;
    logic                w_rise_tick;
    logic                w_fall_tick;
    logic                w_serial_clock;
    logic [c_flat_w-1:0] w_flat;

    assign w_addr_ok  = ({1'b0, cfg_addr} < c_num_pads);
    assign w_wr_ok    = (r_state == c_st_idle) && w_addr_ok;
    assign w_shift_en = (r_state == c_st_shift);

    // Pad 0 occupies the low bits, so the chain order is a countdown from the top.
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_flat
        assign w_flat[p*CFG_BITS +: CFG_BITS] = r_shadow[p];
    end
    assign w_flat[c_flat_w-1:c_total] = '0;

    mprj_io_serial_clkgen #(
        .CLK_DIV        (CLK_DIV)
    ) u_clkgen (
        .clk            (clock),
        .rst            (reset),
        .i_en           (w_shift_en),
        .o_rise_tick    (w_rise_tick),
        .o_fall_tick    (w_fall_tick),
        .o_serial_clock (w_serial_clock)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                r_shadow[i] <= DEFAULT_CFG;
            end
            r_state     <= c_st_idle;
            r_bit_cnt   <= '0;
            r_load_cnt  <= '0;
            r_last_bit  <= 1'b0;
            r_auto_pend <= AUTO_LOAD;
            r_wr_err    <= 1'b0;
        end else begin
            r_auto_pend <= 1'b0;
            r_wr_err    <= cfg_we && !w_wr_ok;
            if (cfg_we && w_wr_ok) begin
                r_shadow[cfg_addr] <= cfg_wdata;
            end

            case (r_state)
                c_st_idle: begin
                    if (xfer_start || r_auto_pend) begin
                        r_state    <= c_st_shift;
                        r_bit_cnt  <= '0;
                        r_last_bit <= 1'b0;
                    end
                end
                c_st_shift: begin
                    // Last-bit compare is captured in the high half, ahead of the fall.
                    if (w_rise_tick) begin
                        r_last_bit <= (r_bit_cnt == c_last_bit);
                    end
                    if (w_fall_tick) begin
                        if (r_last_bit) begin
                            r_state    <= c_st_load;
                            r_load_cnt <= '0;
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_st_load: begin
                    if (r_load_cnt == c_load_last) begin
                        r_state    <= c_st_done;
                    end else begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        r_serial_resetn <= ~reset;
    end

    assign cfg_rdata     = w_addr_ok ? r_shadow[cfg_addr] : '0;
    assign cfg_wr_err    = r_wr_err;
    assign xfer_busy     = (r_state == c_st_shift) || (r_state == c_st_load);
    assign xfer_done     = (r_state == c_st_done);
    assign serial_clock  = w_serial_clock;
    // Shadow is frozen outside IDLE, so this only moves when the bit counter does.
    assign serial_data   = w_shift_en && w_flat[c_last_bit - r_bit_cnt];
    assign serial_load   = (r_state == c_st_load);
    assign serial_resetn = r_serial_resetn;

endmodule
`default_nettype wire

// File: tb/tb_mprj_io_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mprj_io_cfg_sequencer
// Brief  : Scoreboard bench for two sequencer configurations sharing a clock.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mprj_io_cfg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // d0: 2 pads x 4 bits, divide 1, no auto-load
    logic       rst0, we0, start0;
    logic [0:0] addr0;
    logic [3:0] wdata0, rdata0;
    logic       err0, busy0, done0, sclk0, sdat0, sload0, sresetn0;

    // d1: 3 pads x 4 bits, divide 3, auto-load
    logic       rst1, we1, start1;
    logic [1:0] addr1;
    logic [3:0] wdata1, rdata1;
    logic       err1, busy1, done1, sclk1, sdat1, sload1, sresetn1;

    mprj_io_cfg_sequencer #(
        .NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1), .DEFAULT_CFG(4'h3), .AUTO_LOAD(1'b0)
    ) d0 (
        .clock(clk), .reset(rst0), .cfg_addr(addr0), .cfg_wdata(wdata0), .cfg_we(we0),
        .cfg_rdata(rdata0), .cfg_wr_err(err0), .xfer_start(start0), .xfer_busy(busy0),
        .xfer_done(done0), .serial_clock(sclk0), .serial_data(sdat0),
        .serial_load(sload0), .serial_resetn(sresetn0)
    );

    mprj_io_cfg_sequencer #(
        .NUM_PADS(3), .CFG_BITS(4), .CLK_DIV(3), .DEFAULT_CFG(4'h9), .AUTO_LOAD(1'b1)
    ) d1 (
        .clock(clk), .reset(rst1), .cfg_addr(addr1), .cfg_wdata(wdata1), .cfg_we(we1),
        .cfg_rdata(rdata1), .cfg_wr_err(err1), .xfer_start(start1), .xfer_busy(busy1),
        .xfer_done(done1), .serial_clock(sclk1), .serial_data(sdat1),
        .serial_load(sload1), .serial_resetn(sresetn1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    bit exp_bits0[$];
    bit exp_bits1[$];
    int exp_done0[$];
    int exp_done1[$];

    task automatic push_word0(input logic [3:0] w);
        for (int b = 3; b >= 0; b--) exp_bits0.push_back(w[b]);
    endtask

    task automatic push_word1(input logic [3:0] w);
        for (int b = 3; b >= 0; b--) exp_bits1.push_back(w[b]);
    endtask

    // ---------------- monitors ----------------
    bit mon0_en    = 1'b1;
    bit load_seen0 = 1'b0;
    logic prev_sclk0 = 1'b0;
    logic prev_sclk1 = 1'b0;
    int ld0 = 0, ld1 = 0, hi1 = 0, lo1 = 0;

    always @(negedge clk) begin
        if (sclk0 && !prev_sclk0 && mon0_en) begin
            if (exp_bits0.size() == 0) note_fail("d0_extra_bit");
            else check("d0_bit", 32'(sdat0), 32'(exp_bits0.pop_front()));
        end
        prev_sclk0 <= sclk0;
        if (done0) begin
            if (exp_done0.size() == 0) note_fail("d0_extra_done");
            else begin
                check("d0_done_cycle", cyc, exp_done0.pop_front());
                check("d0_busy_at_done", 32'(busy0), 0);
            end
        end
        if (sload0) begin
            ld0 <= ld0 + 1;
            load_seen0 <= 1'b1;
        end else if (ld0 != 0) begin
            check("d0_load_len", ld0, 1);
            ld0 <= 0;
        end
    end

    always @(negedge clk) begin
        if (sclk1 && !prev_sclk1) begin
            if (exp_bits1.size() == 0) note_fail("d1_extra_bit");
            else check("d1_bit", 32'(sdat1), 32'(exp_bits1.pop_front()));
        end
        if (sclk1) begin
            hi1 <= hi1 + 1;
            if (!prev_sclk1 && busy1) check("d1_sclk_low_len", lo1, 3);
            lo1 <= 0;
        end else begin
            if (prev_sclk1) check("d1_sclk_high_len", hi1, 3);
            hi1 <= 0;
            lo1 <= busy1 ? lo1 + 1 : 0;
        end
        prev_sclk1 <= sclk1;
        if (done1) begin
            if (exp_done1.size() == 0) note_fail("d1_extra_done");
            else begin
                check("d1_done_cycle", cyc, exp_done1.pop_front());
                check("d1_busy_at_done", 32'(busy1), 0);
            end
        end
        if (sload1) ld1 <= ld1 + 1;
        else if (ld1 != 0) begin
            check("d1_load_len", ld1, 3);
            ld1 <= 0;
        end
    end

    // ---------------- stimulus ----------------
    int c1;

    initial begin
        rst0 = 1'b1; we0 = 1'b0; start0 = 1'b0; addr0 = '0; wdata0 = '0;
        rst1 = 1'b1; we1 = 1'b0; start1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);

        check("rst_busy0",    32'(busy0),    0);
        check("rst_done0",    32'(done0),    0);
        check("rst_sclk0",    32'(sclk0),    0);
        check("rst_sdat0",    32'(sdat0),    0);
        check("rst_sload0",   32'(sload0),   0);
        check("rst_err0",     32'(err0),     0);
        check("rst_resetn0",  32'(sresetn0), 0);
        check("rst_rdata0",   32'(rdata0),   32'h3);
        check("rst_resetn1",  32'(sresetn1), 0);
        addr1 = 2'd2; #1;
        check("rst_rdata1",   32'(rdata1),   32'h9);

        // Auto-load on d1: default word on every pad, done at 2*3*12+3+1 cycles.
        for (int p = 0; p < 3; p++) push_word1(4'h9);
        c1 = cyc;
        exp_done1.push_back(c1 + 76);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        check("resetn0_release", 32'(sresetn0), 1);
        check("idle_no_auto0",   32'(busy0),    0);
        @(negedge clk);
        check("auto_busy1",      32'(busy1),    1);

        // Pattern transfer on d0.
        addr0 = 1'b1; wdata0 = 4'hA; we0 = 1'b1;
        @(negedge clk);
        addr0 = 1'b0; wdata0 = 4'h5;
        @(negedge clk);
        we0 = 1'b0;
        check("wr_ok_err0", 32'(err0), 0);
        addr0 = 1'b1; #1;
        check("rdata0_pad1", 32'(rdata0), 32'hA);
        push_word0(4'hA);
        push_word0(4'h5);
        exp_done0.push_back(cyc + 18);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("busy0_cycle1", 32'(busy0), 1);

        // Write while busy must bounce.
        addr0 = 1'b0; wdata0 = 4'hF; we0 = 1'b1;
        @(negedge clk);
        we0 = 1'b0;
        check("busy_wr_err0", 32'(err0), 1);
        #1;
        check("busy_wr_rdata0", 32'(rdata0), 32'h5);

        // Re-request mid-SHIFT: ignored.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("err0_one_cycle", 32'(err0), 0);
        repeat (20) @(negedge clk);
        check("d0_bits_left",  exp_bits0.size(), 0);
        check("d0_dones_left", exp_done0.size(), 0);

        // Reset in the middle of SHIFT.
        mon0_en = 1'b0;
        load_seen0 = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy0", 32'(busy0), 1);
        rst0 = 1'b1;
        @(negedge clk);
        check("abort_busy0",   32'(busy0),    0);
        check("abort_sclk0",   32'(sclk0),    0);
        check("abort_sdat0",   32'(sdat0),    0);
        check("abort_sload0",  32'(sload0),   0);
        check("abort_done0",   32'(done0),    0);
        check("abort_resetn0", 32'(sresetn0), 0);
        addr0 = 1'b1; #1;
        check("abort_rdata0_pad1", 32'(rdata0), 32'h3);
        @(negedge clk);
        rst0 = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_load0", 32'(load_seen0), 0);
        check("abort_idle0",    32'(busy0),      0);
        mon0_en = 1'b1;

        // Let the d1 auto-load run out.
        for (int i = 0; i < 200 && cyc < c1 + 80; i++) @(negedge clk);
        check("d1_auto_bits_left",  exp_bits1.size(), 0);
        check("d1_auto_dones_left", exp_done1.size(), 0);

        // Out-of-range address while idle.
        addr1 = 2'd3; wdata1 = 4'h6; we1 = 1'b1;
        @(negedge clk);
        we1 = 1'b0;
        check("badaddr_err1", 32'(err1), 1);
        #1;
        check("badaddr_rdata1", 32'(rdata1), 0);
        addr1 = 2'd2; #1;
        check("badaddr_pad2_kept", 32'(rdata1), 32'h9);

        addr1 = 2'd0; wdata1 = 4'h6; we1 = 1'b1;
        @(negedge clk);
        we1 = 1'b0;
        check("wr_ok_err1", 32'(err1), 0);
        #1;
        check("rdata1_pad0", 32'(rdata1), 32'h6);

        // Write and start in the same cycle: the new pad-2 word is shifted first.
        push_word1(4'hC);
        push_word1(4'h9);
        push_word1(4'h6);
        c1 = cyc;
        exp_done1.push_back(c1 + 76);
        addr1 = 2'd2; wdata1 = 4'hC; we1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        we1 = 1'b0; start1 = 1'b0;
        check("same_cycle_err1",  32'(err1),  0);
        check("same_cycle_busy1", 32'(busy1), 1);
        for (int i = 0; i < 200 && cyc < c1 + 80; i++) @(negedge clk);
        check("d1_bits_left",  exp_bits1.size(), 0);
        check("d1_dones_left", exp_done1.size(), 0);
        check("d1_idle_end",   32'(busy1),       0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
